// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU opcodes and forwarding-mux selects.
package id_ex_stage_pkg;

    localparam logic [3:0] OPAND  = 4'b0000;
    localparam logic [3:0] OPOR   = 4'b0001;
    localparam logic [3:0] OPADD  = 4'b0010;
    localparam logic [3:0] OPSUB  = 4'b0110;
    localparam logic [3:0] OPSLT  = 4'b0111;
    localparam logic [3:0] OPNULL = 4'b1111;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding select for one source register; the MEM result is newer than WB, so it wins.
module forward_unit
    import id_ex_stage_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] iRs,
    input  logic [REG_W-1:0] iMemRd,
    input  logic             iMemRegWrite,
    input  logic [REG_W-1:0] iWbRd,
    input  logic             iWbRegWrite,
    output logic [1:0]       oSel
);

    always_comb begin
        oSel = FWD_REG;
        if (iMemRegWrite && (iMemRd != '0) && (iMemRd == iRs)) begin
            oSel = FWD_MEM;
        end else if (iWbRegWrite && (iWbRd != '0) && (iWbRd == iRs)) begin
            oSel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and MEM/WB forwarding into the ALU operands.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              REG_W    = 5,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iPC,
    input  logic [DATA_W-1:0] iRs1Data,
    input  logic [DATA_W-1:0] iRs2Data,
    input  logic [DATA_W-1:0] iImm,
    input  logic [REG_W-1:0]  iRs1,
    input  logic [REG_W-1:0]  iRs2,
    input  logic [REG_W-1:0]  iRd,
    input  logic [3:0]        iALUControl,
    input  logic              iALUSrc,
    input  logic              iRegWrite,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iBranch,
    input  logic [REG_W-1:0]  iMemRd,
    input  logic              iMemRegWrite,
    input  logic [DATA_W-1:0] iMemResult,
    input  logic [REG_W-1:0]  iWbRd,
    input  logic              iWbRegWrite,
    input  logic [DATA_W-1:0] iWbResult,
    input  logic              iStallExt,
    input  logic              iFlush,
    output logic              oStall,
    output logic              oValid,
    output logic [3:0]        oALUControl,
    output logic [DATA_W-1:0] oA,
    output logic [DATA_W-1:0] oB,
    output logic [DATA_W-1:0] oStoreData,
    output logic [DATA_W-1:0] oPC,
    output logic [REG_W-1:0]  oRd,
    output logic              oRegWrite,
    output logic              oMemRead,
    output logic              oMemWrite,
    output logic              oBranch
);

    logic              valid_q, valid_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_W-1:0]  rs1_q, rs1_d;
    logic [REG_W-1:0]  rs2_q, rs2_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              alusrc_q, alusrc_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q, memread_d;
    logic              memwrite_q, memwrite_d;
    logic              branch_q, branch_d;

    logic              hazard;
    logic [1:0]        sel1, sel2;
    logic [DATA_W-1:0] fwd1, fwd2;

    // Only a load already in this stage can produce a value the decode slot cannot get in time.
    assign hazard = valid_q && memread_q && (rd_q != '0) && iValid &&
                    ((rd_q == iRs1) ||
                     ((rd_q == iRs2) && !iALUSrc) ||
                     ((rd_q == iRs2) && iMemWrite));

    assign oStall = hazard || iStallExt;

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        branch_d   = branch_q;
        if (iFlush || (!iStallExt && hazard)) begin
            valid_d    = 1'b0;
            ctrl_d     = OPNULL;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            branch_d   = 1'b0;
        end else if (!iStallExt) begin
            valid_d    = iValid;
            ctrl_d     = iALUControl;
            pc_d       = iPC;
            rs1_data_d = iRs1Data;
            rs2_data_d = iRs2Data;
            imm_d      = iImm;
            rs1_d      = iRs1;
            rs2_d      = iRs2;
            rd_d       = iRd;
            alusrc_d   = iALUSrc;
            regwrite_d = iRegWrite && iValid;
            memread_d  = iMemRead && iValid;
            memwrite_d = iMemWrite && iValid;
            branch_d   = iBranch && iValid;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            valid_q    <= 1'b0;
            ctrl_q     <= OPNULL;
            pc_q       <= RESET_PC;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            branch_q   <= branch_d;
        end
    end

    forward_unit #(.REG_W(REG_W)) u_fwd_rs1 (
        .iRs          (rs1_q),
        .iMemRd       (iMemRd),
        .iMemRegWrite (iMemRegWrite),
        .iWbRd        (iWbRd),
        .iWbRegWrite  (iWbRegWrite),
        .oSel         (sel1)
    );

    forward_unit #(.REG_W(REG_W)) u_fwd_rs2 (
        .iRs          (rs2_q),
        .iMemRd       (iMemRd),
        .iMemRegWrite (iMemRegWrite),
        .iWbRd        (iWbRd),
        .iWbRegWrite  (iWbRegWrite),
        .oSel         (sel2)
    );

    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                  input logic [DATA_W-1:0] stored,
                                                  input logic [DATA_W-1:0] mem_res,
                                                  input logic [DATA_W-1:0] wb_res);
        case (sel)
            FWD_MEM: fwd_mux = mem_res;
            FWD_WB:  fwd_mux = wb_res;
            default: fwd_mux = stored;
        endcase
    endfunction

    assign fwd1 = fwd_mux(sel1, rs1_data_q, iMemResult, iWbResult);
    assign fwd2 = fwd_mux(sel2, rs2_data_q, iMemResult, iWbResult);

    assign oValid      = valid_q;
    assign oALUControl = ctrl_q;
    assign oA          = fwd1;
    assign oB          = alusrc_q ? imm_q : fwd2;
    assign oStoreData  = fwd2;
    assign oPC         = pc_q;
    assign oRd         = rd_q;
    assign oRegWrite   = regwrite_q && valid_q;
    assign oMemRead    = memread_q && valid_q;
    assign oMemWrite   = memwrite_q && valid_q;
    assign oBranch     = branch_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected stage contents are queued as each step is driven and checked after the edge.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctrl;
    logic        alusrc, rw, mr, mw, br;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_we, wb_we;
    logic [31:0] mem_res, wb_res;
    logic        stall_ext, flush;

    logic        o_stall, o_valid;
    logic [3:0]  o_ctrl;
    logic [31:0] o_a, o_b, o_sd, o_pc;
    logic [4:0]  o_rd;
    logic        o_rw, o_mr, o_mw, o_br;

    int compared = 0;
    int mismatched = 0;

    // mode 0: all fields, mode 1: valid/opcode/controls only, mode 2: valid/controls only
    typedef struct {
        int          mode;
        logic        v;
        logic [3:0]  c;
        logic [31:0] a, b, sd, pc;
        logic [4:0]  rd;
        logic        rw, mr, mw, br;
    } exp_t;
    exp_t sb[$];

    id_ex_stage #(.DATA_W(32), .REG_W(5), .RESET_PC(RST_PC)) dut (
        .iCLK(clk), .iRST(rst), .iValid(valid), .iPC(pc),
        .iRs1Data(d1), .iRs2Data(d2), .iImm(imm),
        .iRs1(rs1), .iRs2(rs2), .iRd(rd),
        .iALUControl(ctrl), .iALUSrc(alusrc),
        .iRegWrite(rw), .iMemRead(mr), .iMemWrite(mw), .iBranch(br),
        .iMemRd(mem_rd), .iMemRegWrite(mem_we), .iMemResult(mem_res),
        .iWbRd(wb_rd), .iWbRegWrite(wb_we), .iWbResult(wb_res),
        .iStallExt(stall_ext), .iFlush(flush),
        .oStall(o_stall), .oValid(o_valid), .oALUControl(o_ctrl),
        .oA(o_a), .oB(o_b), .oStoreData(o_sd), .oPC(o_pc), .oRd(o_rd),
        .oRegWrite(o_rw), .oMemRead(o_mr), .oMemWrite(o_mw), .oBranch(o_br)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        valid = 0; pc = 0; d1 = 0; d2 = 0; imm = 0;
        rs1 = 0; rs2 = 0; rd = 0; ctrl = OPNULL;
        alusrc = 0; rw = 0; mr = 0; mw = 0; br = 0;
        mem_rd = 0; wb_rd = 0; mem_we = 0; wb_we = 0; mem_res = 0; wb_res = 0;
        stall_ext = 0; flush = 0;
    endtask

    task automatic push(input int mode, input logic v, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                        input logic [31:0] p, input logic [4:0] d,
                        input logic erw, input logic emr, input logic emw, input logic ebr);
        exp_t e;
        e.mode = mode; e.v = v; e.c = c; e.a = a; e.b = b; e.sd = sd; e.pc = p; e.rd = d;
        e.rw = erw; e.mr = emr; e.mw = emw; e.br = ebr;
        sb.push_back(e);
    endtask

    task automatic push_bubble();
        push(1, 0, OPNULL, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".valid"}, 32'(o_valid), 32'(e.v));
        chk({tag, ".regwrite"}, 32'(o_rw), 32'(e.rw));
        chk({tag, ".memread"}, 32'(o_mr), 32'(e.mr));
        chk({tag, ".memwrite"}, 32'(o_mw), 32'(e.mw));
        chk({tag, ".branch"}, 32'(o_br), 32'(e.br));
        if (e.mode < 2) chk({tag, ".aluctl"}, 32'(o_ctrl), 32'(e.c));
        if (e.mode == 0) begin
            chk({tag, ".a"}, o_a, e.a);
            chk({tag, ".b"}, o_b, e.b);
            chk({tag, ".store"}, o_sd, e.sd);
            chk({tag, ".pc"}, o_pc, e.pc);
            chk({tag, ".rd"}, 32'(o_rd), 32'(e.rd));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_pop(tag);
    endtask

    initial begin
        idle();
        rst = 1;
        #2;
        chk("rst.valid", 32'(o_valid), 0);
        chk("rst.aluctl", 32'(o_ctrl), 32'(OPNULL));
        chk("rst.pc", o_pc, RST_PC);
        chk("rst.rd", 32'(o_rd), 0);
        chk("rst.a", o_a, 0);
        chk("rst.b", o_b, 0);
        chk("rst.stall", 32'(o_stall), 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // plain capture
        idle(); valid = 1; pc = 32'h10; rs1 = 1; rs2 = 2; rd = 3; d1 = 5; d2 = 7;
        ctrl = OPADD; rw = 1;
        #1 chk("add.stall", 32'(o_stall), 0);
        push(0, 1, OPADD, 5, 7, 7, 32'h10, 3, 1, 0, 0, 0);
        step("add");

        // immediate operand
        idle(); valid = 1; pc = 32'h14; rs1 = 1; rs2 = 2; rd = 4; d1 = 5; d2 = 7;
        imm = 32'hFFFF_FFFC; alusrc = 1; ctrl = OPADD; rw = 1;
        push(0, 1, OPADD, 5, 32'hFFFF_FFFC, 7, 32'h14, 4, 1, 0, 0, 0);
        step("addi");

        // forwarding priority: MEM over WB, then WB alone
        idle(); valid = 1; pc = 32'h18; rs1 = 3; rs2 = 3; rd = 9; d1 = 1; d2 = 2;
        ctrl = OPSUB; rw = 1; br = 1;
        mem_rd = 3; mem_we = 1; mem_res = 11; wb_rd = 3; wb_we = 1; wb_res = 22;
        push(0, 1, OPSUB, 11, 11, 11, 32'h18, 9, 1, 0, 0, 1);
        step("fwd_mem");
        mem_we = 0;
        #1;
        chk("fwd_wb.a", o_a, 22);
        chk("fwd_wb.b", o_b, 22);
        wb_we = 0;
        #1;
        chk("fwd_none.a", o_a, 1);

        // register 0 never forwards
        idle(); valid = 1; pc = 32'h1C; rd = 6; ctrl = OPOR; rw = 1;
        mem_rd = 0; mem_we = 1; mem_res = 99; wb_rd = 0; wb_we = 1; wb_res = 55;
        push(0, 1, OPOR, 0, 0, 0, 32'h1C, 6, 1, 0, 0, 0);
        step("fwd_x0");

        // load into x5
        idle(); valid = 1; pc = 32'h20; rs1 = 1; rd = 5; d1 = 100; imm = 8; alusrc = 1;
        ctrl = OPADD; rw = 1; mr = 1;
        push(0, 1, OPADD, 100, 8, 0, 32'h20, 5, 1, 1, 0, 0);
        step("lw");

        // dependent add: one bubble then capture
        idle(); valid = 1; pc = 32'h24; rs1 = 5; rs2 = 2; rd = 7; d2 = 7; ctrl = OPADD; rw = 1;
        #1 chk("loaduse.stall", 32'(o_stall), 1);
        push_bubble();
        step("loaduse.bubble");
        chk("loaduse.stall_clear", 32'(o_stall), 0);
        push(0, 1, OPADD, 0, 7, 7, 32'h24, 7, 1, 0, 0, 0);
        step("loaduse.add");

        // load then ADDI reading rd via immediate slot: no hazard
        idle(); valid = 1; pc = 32'h28; rs1 = 1; rd = 5; d1 = 4; alusrc = 1;
        ctrl = OPADD; rw = 1; mr = 1;
        push(0, 1, OPADD, 4, 0, 0, 32'h28, 5, 1, 1, 0, 0);
        step("lw2");
        idle(); valid = 1; pc = 32'h2C; rs1 = 1; rs2 = 5; rd = 8; d1 = 4; d2 = 9; imm = 3;
        alusrc = 1; ctrl = OPADD; rw = 1;
        #1 chk("addi_nohaz.stall", 32'(o_stall), 0);
        push(0, 1, OPADD, 4, 3, 9, 32'h2C, 8, 1, 0, 0, 0);
        step("addi_nohaz");

        // external stall holds everything
        for (int i = 0; i < 3; i++) begin
            idle(); valid = 1; pc = 32'h40 + 32'(i * 4); rs1 = 5'(10 + i); rd = 5'(12 + i);
            d1 = 32'(i + 70); ctrl = OPSUB; mw = 1; stall_ext = 1;
            #1 chk("xstall.stall", 32'(o_stall), 1);
            push(0, 1, OPADD, 4, 3, 9, 32'h2C, 8, 1, 0, 0, 0);
            step("xstall.hold");
        end

        // stall with flush: flush wins
        idle(); valid = 1; pc = 32'h4C; ctrl = OPSUB; rw = 1; stall_ext = 1; flush = 1;
        push_bubble();
        step("xstall_flush");

        // flush alone
        idle(); valid = 1; pc = 32'h50; rs1 = 1; rs2 = 2; rd = 3; ctrl = OPSUB;
        rw = 1; mw = 1; flush = 1;
        push_bubble();
        step("flush");

        // invalid decode slot: controls forced off
        idle(); valid = 0; pc = 32'h54; rd = 3; ctrl = OPAND; rw = 1; mr = 1; mw = 1; br = 1;
        push(2, 0, OPNULL, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("invalid");

        // unknown opcode passes through, SLT plus branch
        idle(); valid = 1; pc = 32'h58; rs1 = 2; rs2 = 4; rd = 1; d1 = 32'hA; d2 = 32'hB;
        ctrl = 4'hD; br = 1;
        push(0, 1, 4'hD, 32'hA, 32'hB, 32'hB, 32'h58, 1, 0, 0, 0, 1);
        step("unknown_op");
        idle(); valid = 1; pc = 32'h5C; rs1 = 2; rs2 = 4; rd = 1; d1 = 3; d2 = 6;
        ctrl = OPSLT; rw = 1;
        push(0, 1, OPSLT, 3, 6, 6, 32'h5C, 1, 1, 0, 0, 0);
        step("slt");

        // asynchronous reset between edges while stalled
        idle(); valid = 1; pc = 32'h60; rs1 = 1; rs2 = 2; rd = 3; d1 = 5; d2 = 7;
        ctrl = OPADD; rw = 1;
        push(0, 1, OPADD, 5, 7, 7, 32'h60, 3, 1, 0, 0, 0);
        step("pre_reset");
        stall_ext = 1;
        #2 rst = 1;
        #1;
        chk("async_rst.valid", 32'(o_valid), 0);
        chk("async_rst.aluctl", 32'(o_ctrl), 32'(OPNULL));
        chk("async_rst.pc", o_pc, RST_PC);
        chk("async_rst.rd", 32'(o_rd), 0);
        chk("async_rst.regwrite", 32'(o_rw), 0);
        chk("async_rst.a", o_a, 0);
        @(negedge clk);
        rst = 0;
        idle();

        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
